// File: rtl/led_fade_pwm_pkg.sv
// Shared constants and helpers for the LED fade/PWM stage.
// Pin polarity, default PWM width and the default fade rate derived from the system clock.
package led_fade_pwm_pkg;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  localparam int NUM_CH       = 4;
  localparam int DEF_PWM_BITS = 8;
  localparam int CLK_HZ       = 50_000_000;
  localparam int FADE_MS      = 250;

  // A full 0 -> max ramp takes about FADE_MS; rounded up so the ramp is never faster.
  localparam int DEF_FADE_STEPS    = (1 << DEF_PWM_BITS) - 1;
  localparam int DEF_FADE_STEP_CYC =
    ((CLK_HZ / 1000) * FADE_MS + DEF_FADE_STEPS - 1) / DEF_FADE_STEPS;

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: duty register that ramps toward its target on each step tick,
// and a PWM compare that produces the registered active-low pin drive.
module led_fade_chan
  import led_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_on,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                step_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_n,
  output logic                busy_ch
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] target;
  logic                led_n_q, led_n_d;
  logic                pwm_on;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    target  = req_on ? brightness : '0;
    duty_d  = duty_q;
    if (step_tick) begin
      if (duty_q < target) begin
        duty_d = duty_q + PWM_BITS'(1);
      end else if (duty_q > target) begin
        duty_d = duty_q - PWM_BITS'(1);
      end
    end
    // Full-scale duty is forced on so the LED never blinks off for the one tick pwm_cnt==max.
    pwm_on  = (duty_q == DUTY_MAX) || (pwm_cnt < duty_q);
    led_n_d = pwm_on ? LED_ON : LED_OFF;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q  <= '0;
      led_n_q <= LED_OFF;
    end else begin
      duty_q  <= duty_d;
      led_n_q <= led_n_d;
    end
  end

  assign led_n   = led_n_q;
  assign busy_ch = (duty_q != target);

endmodule

// File: rtl/led_fade_pwm.sv
// Fades the sequencer's active-low 4-LED pattern in and out with per-channel PWM.
// Holds the input registers, the shared PWM/step timebase and the busy reduction.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS      = DEF_PWM_BITS,
  parameter int PWM_DIV       = 1,
  parameter int FADE_STEP_CYC = DEF_FADE_STEP_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [NUM_CH-1:0]   led_out,
  output logic                busy
);

  localparam int DIV_W  = cnt_width(PWM_DIV);
  localparam int STEP_W = cnt_width(FADE_STEP_CYC);

  logic [NUM_CH-1:0]   led_in_q, led_in_d;
  logic [PWM_BITS-1:0] brightness_q, brightness_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                busy_q, busy_d;

  logic                div_wrap;
  logic                step_tick;
  logic [NUM_CH-1:0]   led_n;
  logic [NUM_CH-1:0]   busy_ch;

  always_comb begin
    led_in_d     = led_in;
    brightness_d = brightness;

    div_wrap  = (div_cnt_q == DIV_W'(PWM_DIV - 1));
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    pwm_cnt_d = div_wrap ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;

    // The step timebase is free-running and shared, so channels ramp in lockstep.
    step_tick  = (step_cnt_q == STEP_W'(FADE_STEP_CYC - 1));
    step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_W'(1);

    busy_d = |busy_ch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_in_q     <= {NUM_CH{LED_OFF}};
      brightness_q <= '0;
      div_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      step_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      led_in_q     <= led_in_d;
      brightness_q <= brightness_d;
      div_cnt_q    <= div_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      step_cnt_q   <= step_cnt_d;
      busy_q       <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    led_fade_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .req_on     (led_in_q[i] == LED_ON),
      .brightness (brightness_q),
      .step_tick  (step_tick),
      .pwm_cnt    (pwm_cnt_q),
      .led_n      (led_n[i]),
      .busy_ch    (busy_ch[i])
    );
  end

  assign led_out = led_n;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: a cycle-level arithmetic model checked every clock,
// plus directed fade, duty, reversal, brightness-change and async-reset scenarios.
module tb_led_fade_pwm;

  localparam int PWM_BITS = 8;
  localparam int PWM_DIV  = 1;
  localparam int FADE     = 4;
  localparam int NCH      = 4;
  localparam int PERIOD   = 1 << PWM_BITS;
  localparam int DMAX     = PERIOD - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      led_in;
  logic [PWM_BITS-1:0] brightness;
  logic [NCH-1:0]      led_out;
  logic                busy;

  int n_tests = 0;
  int n_fail  = 0;

  led_fade_pwm #(
    .PWM_BITS      (PWM_BITS),
    .PWM_DIV       (PWM_DIV),
    .FADE_STEP_CYC (FADE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .brightness (brightness),
    .led_out    (led_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is a cycle count k since reset release: step ticks fall on k%FADE==FADE-1 and the
  // PWM phase is (k/PWM_DIV) mod PERIOD. Outputs reflect the model state one clock earlier.
  int             m_duty [NCH];
  logic [NCH-1:0] m_req_n;
  int             m_bright;
  longint         m_k;
  logic [NCH-1:0] exp_led;
  logic           exp_busy;
  bit             cmp_en = 1'b0;
  int             m_pwm;
  int             m_tgt;
  bit             m_any;

  function automatic int target_of(input int ch);
    return m_req_n[ch] ? 0 : m_bright;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) m_duty[i] = 0;
      m_req_n  = '1;
      m_bright = 0;
      m_k      = 0;
      exp_led  = '1;
      exp_busy = 1'b0;
    end else begin
      m_pwm = int'((m_k / PWM_DIV) % PERIOD);
      m_any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        exp_led[i] = !((m_duty[i] == DMAX) || (m_pwm < m_duty[i]));
        if (m_duty[i] != target_of(i)) m_any = 1'b1;
      end
      exp_busy = m_any;
      if ((m_k % FADE) == FADE - 1) begin
        for (int i = 0; i < NCH; i++) begin
          m_tgt = target_of(i);
          if (m_duty[i] < m_tgt) m_duty[i] = m_duty[i] + 1;
          else if (m_duty[i] > m_tgt) m_duty[i] = m_duty[i] - 1;
        end
      end
      m_req_n  = led_in;
      m_bright = int'(brightness);
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_led_out", 32'(led_out), 32'(exp_led));
      check("cyc_busy", 32'(busy), 32'(exp_busy));
    end
  end

  // ---------------- directed helpers ----------------
  // Call right after changing an input at a negedge; n counts negedges until busy drops.
  task automatic wait_settle(input string name, input int ticks, output int n);
    int budget;
    budget = ticks * FADE + 20;
    n = 0;
    repeat (2) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_range({name, "_settle_cycles"}, n, ticks * FADE - 1, ticks * FADE + 2);
  endtask

  task automatic count_on(input int ch, output int c);
    c = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (led_out[ch] == 1'b0) c++;
    end
  endtask

  task automatic wait_model_duty(input string name, input int ch, input int val, input int budget);
    int n;
    n = 0;
    while (m_duty[ch] != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached"}, 32'(m_duty[ch]), 32'(val));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int c;
    rst        = 1'b1;
    led_in     = 4'b0000;
    brightness = 8'd255;

    // 1. reset, then idle with all LEDs requested off
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_led_out", 32'(led_out), 32'hF);
    check("reset_busy", 32'(busy), 32'd0);
    led_in = 4'b1111;
    rst    = 1'b0;
    c = 0;
    repeat (300) begin
      @(negedge clk);
      if (led_out == 4'b1111 && busy == 1'b0) c++;
    end
    check("idle_all_off_cycles", 32'(c), 32'd300);

    // 2. fade-in to full brightness on channel 0
    led_in = 4'b1110;
    wait_settle("fade_in", 255, n);
    check("fade_in_model_duty", 32'(m_duty[0]), 32'd255);
    count_on(0, c);
    check("full_on_cycles", 32'(c), 32'd256);
    check("others_off", 32'(led_out[3:1]), 32'b111);
    check("full_on_busy", 32'(busy), 32'd0);

    // 3. duty accuracy at 64
    brightness = 8'd64;
    wait_settle("to_64", 191, n);
    count_on(0, c);
    check("duty64_on_cycles", 32'(c), 32'd64);
    led_in = 4'b1111;
    wait_settle("off_from_64", 64, n);

    // 4. reversal at duty 100
    brightness = 8'd255;
    led_in     = 4'b1110;
    wait_model_duty("rev_up", 0, 100, 600);
    led_in = 4'b1111;
    wait_settle("reversal", 100, n);
    check("reversal_model_duty", 32'(m_duty[0]), 32'd0);
    count_on(0, c);
    check("reversal_off_cycles", 32'(c), 32'd0);
    check("reversal_busy", 32'(busy), 32'd0);

    // 5. brightness change while on: 200 -> 50
    brightness = 8'd200;
    led_in     = 4'b1110;
    wait_settle("to_200", 200, n);
    count_on(0, c);
    check("duty200_on_cycles", 32'(c), 32'd200);
    brightness = 8'd50;
    wait_settle("to_50", 150, n);
    count_on(0, c);
    check("duty50_on_cycles", 32'(c), 32'd50);

    // 6. async reset mid-fade at duty 128, then restart from 0
    led_in = 4'b1111;
    wait_settle("off_from_50", 50, n);
    brightness = 8'd255;
    led_in     = 4'b1110;
    wait_model_duty("pre_reset", 0, 128, 800);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_led_out", 32'(led_out), 32'hF);
    check("async_reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_settle("restart", 255, n);
    check("restart_model_duty", 32'(m_duty[0]), 32'd255);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
